cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the CPU data port and the main memory model.
- Accepts CPU byte read and write requests and serves read hits from internal storage.
- On a read miss, fetches the byte from main memory and fills the line.
- Propagates every write to main memory.
- Drives the memory-side bus MMRead/MMWrite/ABUS/CachetoMem and consumes MemtoCache. Memory has no ready signal, so the controller holds each memory access for a fixed number of cycles.

Parameters:
- DATA_W, 8, data byte width.
- ADDR_W, 8, address width.
- INDEX_W, 4, index bits; lines = 2**INDEX_W; tag width = ADDR_W-INDEX_W.
- MM_WAIT_CYCLES, 2, cycles each memory strobe is held (>=1; must cover memory delay).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- CpuRead  in  1  read request, held until CpuReady.
- CpuWrite  in  1  write request, held until CpuReady.
- CpuAddr  in  ADDR_W  request address, stable while request held.
- CpuWData  in  DATA_W  write data.
- CpuRData  out  DATA_W  read data, valid while CpuReady=1 for a read.
- CpuReady  out  1  one-cycle completion pulse.
- MMRead  out  1  memory read strobe.
- MMWrite  out  1  memory write strobe.
- ABUS  out  ADDR_W  memory address.
- CachetoMem  out  DATA_W  memory write data.
- MemtoCache  in  DATA_W  memory read data.
- HitCount  out  8  read hits, saturating at 255.
- MissCount  out  8  read misses, saturating at 255.

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (RST_N).

Reset:
- State=IDLE.
- All valid bits=0; tag and data arrays need not be cleared.
- CpuRData=0, CpuReady=0, MMRead=0, MMWrite=0, ABUS=0, CachetoMem=0, HitCount=0, MissCount=0.
- Reset mid-access aborts immediately: strobes drop asynchronously, and no line is filled or updated.

Outputs and addressing:
- All outputs are registered.
- MMRead and MMWrite are never both 1.
- ABUS and CachetoMem hold their last value when idle.
- index=CpuAddr[INDEX_W-1:0]; tag=CpuAddr[ADDR_W-1:INDEX_W]; hit = valid[index] && tag_q[index]==tag.

States: IDLE, RD_MISS, WR_THRU, RESP.

IDLE, request sampled at edge E0:
- CpuWrite=1 (wins if CpuRead also 1):
  - If hit, the line data is updated to CpuWData at E0.
  - If miss, the line is untouched (no allocate).
  - MMWrite<=1, ABUS<=CpuAddr, CachetoMem<=CpuWData, counter<=0, go to WR_THRU.
- CpuRead=1 and hit:
  - CpuRData<=line data, CpuReady<=1, HitCount++ (saturating), go to RESP.
- CpuRead=1 and miss:
  - MMRead<=1, ABUS<=CpuAddr, counter<=0, MissCount++ (saturating), go to RD_MISS.
- No request: stay in IDLE.

RD_MISS:
- counter increments each edge.
- At the edge where counter==MM_WAIT_CYCLES-1:
  - Capture MemtoCache into line data, CpuRData, tag and valid.
  - MMRead<=0, CpuReady<=1, go to RESP.
- MMRead is therefore high for exactly MM_WAIT_CYCLES cycles.

WR_THRU:
- Same counting as RD_MISS.
- At the final edge: MMWrite<=0, CpuReady<=1, go to RESP.
- Write counters are not affected.

RESP:
- CpuReady high for this single cycle; cleared on exit. Go to IDLE.
- Requests present during RESP are ignored. The CPU may change or drop its request on the edge that ends RESP.

Latency and throughput:
- Read hit: CpuReady in the cycle after E0.
- Read miss and write: CpuReady in the cycle after E0+MM_WAIT_CYCLES.
- Maximum rate is one request per 2 cycles (hit).

Boundary cases:
- A request dropped before CpuReady is not supported; the outcome is undefined (bench does not test it).
- A conflicting miss to the same index replaces the line.
- Index wrap: addresses 0x0F and 0x1F map to the same line.
- Counters saturate: 255 stays 255.

Decomposition:
- Shared package cache_pkg holds:
  - state encoding constants IDLE=2'd0, RD_MISS=2'd1, WR_THRU=2'd2, RESP=2'd3;
  - default widths DATA_W/ADDR_W/INDEX_W.
- Sub-module cache_line_store: valid/tag/data arrays.
  - Async-clear of valid bits on RST_N.
  - Combinational lookup returns hit and data.
  - Single synchronous write port for fill/update.
- cache_ctrl keeps the FSM, wait counter, memory-bus registers and statistics counters.

Test Plan:
- Reset, then read 0x23 (memory holds 0x5A) -> MMRead high 2 cycles with ABUS=0x23; CpuReady with CpuRData=0x5A; MissCount=1.
- Repeat read 0x23 -> no MMRead; CpuReady one cycle after request with 0x5A; HitCount=1.
- Write 0x23<=0xC3 -> MMWrite high 2 cycles with ABUS=0x23, CachetoMem=0xC3; memory[0x23]=0xC3; next read 0x23 hits and returns 0xC3.
- Write 0x44<=0x11 (miss), then read 0x44 -> write does not allocate; the read misses; MissCount increments.
- Read 0x13 (miss, same index as 0x23) then read 0x23 -> both miss (line replaced); ABUS follows each address.
- Assert RST_N=0 mid RD_MISS -> MMRead drops immediately; after release, a read of the same address misses (valid cleared); HitCount=MissCount=0 before it.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the controller state encoding and the default bus widths.
package cache_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INDEX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for a direct-mapped cache.
// Lookup is combinational; a single synchronous port fills or updates a line.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INDEX_W = DEF_INDEX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    logic [LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;

    assign index   = addr[INDEX_W-1:0];
    assign tag     = addr[ADDR_W-1:INDEX_W];
    assign hit     = valid_reg[index] && (tag_mem[index] == tag);
    assign rd_data = data_mem[index];

    // Only the valid bits need clearing; stale tag/data are masked by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= wr_data;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Memory has no handshake, so every access holds its strobe a fixed number of cycles.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int INDEX_W        = DEF_INDEX_W,
    parameter int MM_WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CpuRead,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic [DATA_W-1:0] CpuRData,
    output logic              CpuReady,
    output logic              MMRead,
    output logic              MMWrite,
    output logic [ADDR_W-1:0] ABUS,
    output logic [DATA_W-1:0] CachetoMem,
    input  logic [DATA_W-1:0] MemtoCache,
    output logic [7:0]        HitCount,
    output logic [7:0]        MissCount
);

    localparam int CNT_W = (MM_WAIT_CYCLES > 1) ? $clog2(MM_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_WAIT_CYCLES - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              hit;
    logic [DATA_W-1:0] line_data;
    logic              cnt_done;
    logic              store_wr_en;
    logic [DATA_W-1:0] store_wr_data;

    assign cnt_done = (cnt_reg == CNT_LAST);

    // Write hits update the line at request time; read misses fill on the last wait edge.
    always_comb begin
        store_wr_en   = 1'b0;
        store_wr_data = MemtoCache;
        if (state_reg == IDLE && CpuWrite && hit) begin
            store_wr_en   = 1'b1;
            store_wr_data = CpuWData;
        end else if (state_reg == RD_MISS && cnt_done) begin
            store_wr_en   = 1'b1;
        end
    end

    cache_line_store #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .INDEX_W (INDEX_W)
    ) u_store (
        .clk     (CLK),
        .rst_n   (RST_N),
        .addr    (CpuAddr),
        .hit     (hit),
        .rd_data (line_data),
        .wr_en   (store_wr_en),
        .wr_data (store_wr_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            CpuRData   <= '0;
            CpuReady   <= 1'b0;
            MMRead     <= 1'b0;
            MMWrite    <= 1'b0;
            ABUS       <= '0;
            CachetoMem <= '0;
            HitCount   <= '0;
            MissCount  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (CpuWrite) begin
                        MMWrite    <= 1'b1;
                        ABUS       <= CpuAddr;
                        CachetoMem <= CpuWData;
                        cnt_reg    <= '0;
                        state_reg  <= WR_THRU;
                    end else if (CpuRead && hit) begin
                        CpuRData  <= line_data;
                        CpuReady  <= 1'b1;
                        HitCount  <= (HitCount == 8'hFF) ? HitCount : HitCount + 8'd1;
                        state_reg <= RESP;
                    end else if (CpuRead) begin
                        MMRead    <= 1'b1;
                        ABUS      <= CpuAddr;
                        cnt_reg   <= '0;
                        MissCount <= (MissCount == 8'hFF) ? MissCount : MissCount + 8'd1;
                        state_reg <= RD_MISS;
                    end
                end
                RD_MISS: begin
                    if (cnt_done) begin
                        CpuRData  <= MemtoCache;
                        MMRead    <= 1'b0;
                        CpuReady  <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WR_THRU: begin
                    if (cnt_done) begin
                        MMWrite   <= 1'b0;
                        CpuReady  <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    CpuReady  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
